// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer and its datapath.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/right_shift_register.sv
// Single-position right shift register; no reset, the controller qualifies its output.
module right_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shift_q;
    logic             fill;

    assign fill = (mode == MODE_ARITH) ? d[WIDTH-1] : 1'b0;

    always_comb begin
        shift_d = shift_q;
        if (en) begin
            shift_d = {fill, d[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign q = shift_q;

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a 1-bit right shift register to perform a 0..WIDTH position shift.
// Define STICKY_EN to add result_sticky (OR of all bits shifted out).
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_data,
    input  logic [AMT_W-1:0] start_amt,
    input  logic             start_mode,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_data,
`ifdef STICKY_EN
    output logic             result_sticky,
`endif
    output logic             busy
);

    state_t           state_d, state_q;
    logic [AMT_W-1:0] count_d, count_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic             mode_d, mode_q;
    logic             bypass_d, bypass_q;
    logic [AMT_W-1:0] amt_sat;

    logic             sr_en;
    logic             sr_mode;
    logic [WIDTH-1:0] sr_in;
    logic [WIDTH-1:0] sr_out;

`ifdef STICKY_EN
    logic             sticky_d, sticky_q;
`endif

    // Shifting further than WIDTH gives the same result as WIDTH.
    assign amt_sat = (start_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : start_amt;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        data_d   = data_q;
        mode_d   = mode_q;
        bypass_d = bypass_q;
        sr_en    = 1'b0;
        sr_mode  = mode_q;
        sr_in    = sr_out;
`ifdef STICKY_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                sr_in   = start_data;
                sr_mode = start_mode;
                if (start_valid) begin
                    mode_d   = start_mode;
                    data_d   = start_data;
                    bypass_d = (amt_sat == '0);
`ifdef STICKY_EN
                    sticky_d = (amt_sat != '0) & start_data[0];
`endif
                    if (amt_sat == '0) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        // The accepting edge already performs the first shift.
                        sr_en   = 1'b1;
                        count_d = amt_sat - AMT_W'(1);
                        state_d = (amt_sat == AMT_W'(1)) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_en   = 1'b1;
                count_d = count_q - AMT_W'(1);
`ifdef STICKY_EN
                sticky_d = sticky_q | sr_out[0];
`endif
                if (count_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            data_q   <= '0;
            mode_q   <= MODE_ARITH;
            bypass_q <= 1'b0;
`ifdef STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            bypass_q <= bypass_d;
`ifdef STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    right_shift_register #(
        .WIDTH (WIDTH)
    ) u_sr (
        .clk  (clk),
        .en   (sr_en),
        .mode (sr_mode),
        .d    (sr_in),
        .q    (sr_out)
    );

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign result_data  = (state_q != DONE) ? '0 : (bypass_q ? data_q : sr_out);
`ifdef STICKY_EN
    assign result_sticky = (state_q == DONE) & sticky_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (build with STICKY_EN to cover result_sticky).
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AMT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] start_data;
    logic [AMT_W-1:0] start_amt;
    logic             start_mode;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result_data;
    logic             busy;
`ifdef STICKY_EN
    logic             result_sticky;
`endif

    int errors = 0;
    int checks = 0;
    int enCount = 0;

    shift_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_data   (start_data),
        .start_amt    (start_amt),
        .start_mode   (start_mode),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
`ifdef STICKY_EN
        .result_sticky(result_sticky),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.sr_en) enCount <= enCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitResult(inout int lat);
        while (!result_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic consumeResult(input string tag);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        checkOutput({tag, "_rv_after"}, 32'(result_valid), 32'd0);
        checkOutput({tag, "_rdy_after"}, 32'(start_ready), 32'd1);
    endtask

    // Called at a negedge with the block idle; mode is flipped after acceptance.
    task automatic applyStimulus(input string tag, input logic [15:0] data, input logic [4:0] amt,
                                 input logic mode, input logic [15:0] expData, input int expLat,
                                 input logic expSticky, output int enPulses);
        int lat;
        int enBefore;
        checkOutput({tag, "_rdy"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        start_data  = data;
        start_amt   = amt;
        start_mode  = mode;
        enBefore    = enCount;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_valid = 1'b0;
        start_mode  = ~mode;
        start_data  = 16'hFFFF;
        waitResult(lat);
        enPulses = enCount - enBefore;
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_data"}, 32'(result_data), 32'(expData));
`ifdef STICKY_EN
        checkOutput({tag, "_sticky"}, 32'(result_sticky), 32'(expSticky));
`else
        if (expSticky === 1'bx) $display("[TB] note: unexpected sticky value");
`endif
        consumeResult(tag);
    endtask

    initial begin
        int en;
        int lat;
        reset        = 1'b1;
        start_valid  = 1'b0;
        start_data   = '0;
        start_amt    = '0;
        start_mode   = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(start_ready), 32'd1);
        checkOutput("rst_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_data", 32'(result_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        applyStimulus("arith3", 16'h8000, 5'd3, 1'b0, 16'hF000, 3, 1'b0, en);
        applyStimulus("logic3", 16'h8000, 5'd3, 1'b1, 16'h1000, 3, 1'b0, en);
        applyStimulus("logic1", 16'h0003, 5'd1, 1'b1, 16'h0001, 1, 1'b1, en);
        applyStimulus("bypass", 16'hA5A5, 5'd0, 1'b0, 16'hA5A5, 1, 1'b0, en);
        checkOutput("bypass_en", 32'(en), 32'd0);
        applyStimulus("sat_ar", 16'h8001, 5'd31, 1'b0, 16'hFFFF, 16, 1'b1, en);
        applyStimulus("sat_lg", 16'h8001, 5'd31, 1'b1, 16'h0000, 16, 1'b1, en);
        applyStimulus("full16", 16'h7FFF, 5'd16, 1'b0, 16'h0000, 16, 1'b1, en);
        checkOutput("full16_en", 32'(en), 32'd16);
        applyStimulus("stk1", 16'h0005, 5'd2, 1'b1, 16'h0001, 2, 1'b1, en);
        applyStimulus("stk0", 16'h0004, 5'd2, 1'b1, 16'h0001, 2, 1'b0, en);

        // Back-pressure with a second request waiting.
        start_valid = 1'b1;
        start_data  = 16'h8000;
        start_amt   = 5'd3;
        start_mode  = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_data = 16'h00F0;
        start_amt  = 5'd4;
        waitResult(lat);
        checkOutput("bp_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_data", 32'(result_data), 32'h1000);
            checkOutput("bp_rdy", 32'(start_ready), 32'd0);
            checkOutput("bp_valid", 32'(result_valid), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        consumeResult("bp");
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_valid = 1'b0;
        waitResult(lat);
        checkOutput("queued_lat", 32'(lat), 32'd4);
        checkOutput("queued_data", 32'(result_data), 32'h000F);
        consumeResult("queued");

        // Reset in the fourth cycle of a long shift.
        start_valid = 1'b1;
        start_data  = 16'h8000;
        start_amt   = 5'd10;
        start_mode  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_rdy", 32'(start_ready), 32'd1);
        checkOutput("mid_valid", 32'(result_valid), 32'd0);
        checkOutput("mid_data", 32'(result_data), 32'd0);
        checkOutput("mid_busy0", 32'(busy), 32'd0);
        applyStimulus("post_rst", 16'h8000, 5'd2, 1'b0, 16'hE000, 2, 1'b0, en);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
